mem_stage_access_ctrl: RTL
==========================

// Module: mem_stage_access_ctrl
// PURPOSE
//  MEM-stage consumer of the EXE->MEM pipeline register. Turns its memory control fields into a
//  req/ack transaction on the data-cache port and handles byte lanes for LB/SB.
//  Drives the pipeline-wide freeze while an access is outstanding, so upstream stage registers hold.
//  Returns load data to the MEM->WB register.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in ACCESS before abort (only with MEM_TIMEOUT_EN)
//  LB_SIGN_EXT     1    1: LB sign-extends the byte; 0: zero-extends
// PORTS
//  clk          in   1   clock, rising edge
//  rst_b        in   1   reset, asynchronous, active-low
//  mem_write    in   1   store request from EXE->MEM register
//  mem_to_reg   in   1   load request from EXE->MEM register
//  cache_en     in   1   memory access enable; 0 = instruction has no memory access
//  is_LB_SB     in   1   1 = byte access, 0 = word access
//  alu_result   in   32  effective byte address
//  rt_data      in   32  store data
//  mem_req      out  1   cache request, held high until mem_ack
//  mem_we       out  1   1 = write, 0 = read
//  mem_addr     out  32  word address {alu_result[31:2],2'b00}
//  mem_wdata    out  32  write data
//  mem_wstrb    out  4   byte write strobes; bit i = byte i (little-endian)
//  mem_rdata    in   32  read data, valid with mem_ack
//  mem_ack      in   1   one-cycle completion pulse
//  freeze       out  1   stall request to all stage registers
//  load_data    out  32  aligned/extended load result to MEM->WB
//  load_valid   out  1   one-cycle pulse: load_data updated
//  mem_err      out  1   sticky timeout flag (tied 0 without MEM_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
//         load_data=0, load_valid=0, mem_err=0, freeze=0.
//         Reset asynchronously aborts any access; mem_req drops immediately.
//  req_in = cache_en & (mem_write | mem_to_reg). If mem_write and mem_to_reg are both 1, it is a store.
//  FSM IDLE -> ACCESS -> DONE -> IDLE:
//   IDLE:   if req_in, register mem_req=1, mem_we, mem_addr, mem_wdata, mem_wstrb; go to ACCESS.
//           freeze is combinational: freeze = req_in while in IDLE.
//   ACCESS: freeze=1. mem_req/we/addr/wdata/wstrb stay stable.
//           On mem_ack: mem_req<=0; if load, load_data<=extracted rdata; go to DONE.
//           mem_ack outside ACCESS is ignored.
//   DONE:   freeze=0 and inputs ignored, because EXE->MEM still holds the completed instruction.
//           Do not re-issue. load_valid=1 if the op was a load. Next state is IDLE.
//  Latency: minimum 3 cycles per access with mem_ack in the first ACCESS cycle; freeze high 2 cycles.
//           freeze stays high for (ack delay + 1) cycles.
//  Store word: wstrb=4'hF, wdata=rt_data. alu_result[1:0] is ignored (no misalign trap).
//  Store byte: wstrb=4'b0001<<alu_result[1:0], wdata={4{rt_data[7:0]}}.
//  Load word: load_data=mem_rdata.
//  Load byte: b=mem_rdata[8*a+:8] with a=alu_result[1:0]; load_data = LB_SIGN_EXT ? {{24{b[7]}},b} : {24'b0,b}.
//  No memory op (req_in=0): no stall, no request; load_data holds its value.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: an 8+-bit counter runs in ACCESS.
//   At TIMEOUT_CYCLES with no ack: drop mem_req; set mem_err=1 (sticky until reset).
//   A load returns load_data=32'hDEADBEEF; go to DONE as normal.
//  MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; mem_err tied 0.
// TESTING
//  LW, addr 0x100, ack in 1st ACCESS cycle, rdata 0x12345678
//    -> freeze high 2 cycles, mem_addr=0x100, load_data=0x12345678, load_valid 1 pulse.
//  SB, addr 0x203, rt_data=0xAABBCC5A
//    -> mem_we=1, mem_addr=0x200, wstrb=4'b1000, wdata=0x5A5A5A5A, load_valid stays 0.
//  LB, addr 0x301, rdata 0x00008000, LB_SIGN_EXT=1 -> load_data=0xFFFFFF80.
//    Same with LB_SIGN_EXT=0 -> 0x00000080.
//  LW with ack delayed 5 cycles
//    -> freeze high 6 cycles, mem_req/addr stable throughout, exactly one request issued.
//  rst_b low mid-ACCESS -> mem_req and freeze drop at once; a late mem_ack after reset is ignored.
//  ALU op (cache_en=0) -> no mem_req, freeze stays 0.
//    With MEM_TIMEOUT_EN and no ack: mem_err=1 after TIMEOUT_CYCLES; load_data=0xDEADBEEF.

Source files
------------

// File: rtl/mem_stage_access_ctrl_if.sv
// mem_stage_access_ctrl_if: data-cache req/ack port between the MEM stage and the cache
interface mem_stage_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_stage_access_ctrl.sv
// mem_stage_access_ctrl: MEM-stage cache access FSM with pipeline freeze and LB/SB byte lanes
// Optional access timeout with sticky mem_err when MEM_TIMEOUT_EN is defined.
module mem_stage_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit LB_SIGN_EXT    = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_b,
    input  logic                           mem_write,
    input  logic                           mem_to_reg,
    input  logic                           cache_en,
    input  logic                           is_LB_SB,
    input  logic [31:0]                    alu_result,
    input  logic [31:0]                    rt_data,
    mem_stage_access_ctrl_if.master        bus,
    output logic                           freeze,
    output logic [31:0]                    load_data,
    output logic                           load_valid,
    output logic                           mem_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      state, next;
    logic        req_in, timeout, lb_r;
    logic [1:0]  off_r;
    logic [7:0]  b;
    logic [31:0] ext;

    assign req_in     = cache_en & (mem_write | mem_to_reg);
    assign load_valid = (state == DONE) & ~bus.mem_we;
    assign b          = bus.mem_rdata[8*off_r +: 8];
    assign ext        = lb_r ? {LB_SIGN_EXT ? {24{b[7]}} : 24'b0, b} : bus.mem_rdata;

    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) state <= IDLE;
        else        state <= next;

    // rst_b gates freeze so an asserted request cannot stall the pipe during reset
    always_comb begin
        next   = IDLE;
        freeze = 1'b0;
        next   = state == IDLE   ? (req_in ? ACCESS : IDLE) :
                 state == ACCESS ? ((bus.mem_ack | timeout) ? DONE : ACCESS) : IDLE;
        freeze = rst_b & ((state == ACCESS) | ((state == IDLE) & req_in));
    end

    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
            load_data     <= '0;
            off_r         <= '0;
            lb_r          <= 1'b0;
        end else if (state == IDLE && req_in) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= mem_write;
            bus.mem_addr  <= {alu_result[31:2], 2'b00};
            bus.mem_wdata <= is_LB_SB ? {4{rt_data[7:0]}} : rt_data;
            bus.mem_wstrb <= mem_write ? (is_LB_SB ? 4'b0001 << alu_result[1:0] : 4'hF) : 4'h0;
            off_r         <= alu_result[1:0];
            lb_r          <= is_LB_SB;
        end else if (state == ACCESS && (bus.mem_ack || timeout)) begin
            bus.mem_req <= 1'b0;
            if (!bus.mem_we) load_data <= bus.mem_ack ? ext : 32'hDEADBEEF;
        end

`ifdef MEM_TIMEOUT_EN
    localparam int TW = TIMEOUT_CYCLES > 255 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] cnt;

    assign timeout = (state == ACCESS) & ~bus.mem_ack & (cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            cnt <= state == ACCESS ? cnt + 1'b1 : '0;
            if (timeout) mem_err <= 1'b1;
        end
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif
endmodule
